opcode_fetch: RTL
=================

# opcode_fetch

Prefetch stage that sits directly upstream of the control unit. It issues sequential byte reads to memory from a tracked fetch PC and buffers the returned bytes, each tagged with its address, in a small FIFO. It presents the head byte to the control unit through a valid/take handshake. A flush reloads the fetch PC on a taken branch, jump or vector load.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..8
- RESET_PC, 16'h0200, fetch PC loaded at reset
- ph1  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- mem_req  out  1  read request to memory
- mem_addr  out  16  read address; stable while mem_req is high
- mem_ack  in  1  read completes this cycle; mem_data is valid
- mem_data  in  8  read data
- flush  in  1  discard all buffered and in-flight bytes; restart at flush_pc
- flush_pc  in  16  new fetch PC, sampled when flush is high
- irq  in  1  interrupt pending (used only with the configuration macro)
- op_valid  out  1  head entry available
- op_data  out  8  head byte
- op_pc  out  16  address of head byte
- op_take  in  1  control consumes the head entry this cycle
- count  out  3  number of occupied entries

## Operation
- FIFO storage holds entries of {byte, pc}.
  - op_valid = (count != 0).
  - op_data and op_pc come combinationally from the head entry. They are 8'h00 and 16'h0000 when the FIFO is empty.
- Pop happens only when op_take & op_valid. A take while empty is ignored.
- Memory FSM has three states:
  - IDLE: mem_req=0. Moves to REQ when the FIFO has a free slot after this cycle's pop and flush=0.
  - REQ: mem_req=1, mem_addr=fetch_pc.
    - On mem_ack, push {mem_data, fetch_pc} and set fetch_pc <= fetch_pc+1. The increment wraps 16'hFFFF→16'h0000.
    - After the ack, stay in REQ if post-push/post-pop count < DEPTH; otherwise go to IDLE.
  - DROP: a flush arrived while a request was outstanding. mem_req stays 1 with the old mem_addr. On mem_ack the data is discarded and the FSM goes to REQ at the new fetch_pc.
- mem_req, once raised, holds with a constant mem_addr until mem_ack. A request is never withdrawn.
- Flush takes effect at the next edge and has priority over push and pop:
  - FIFO is cleared (count <= 0) and fetch_pc <= flush_pc.
  - In REQ without mem_ack: go to DROP.
  - In REQ with mem_ack in the same cycle: data is discarded; go to REQ at flush_pc.
  - In IDLE: go to REQ.
  - In DROP: fetch_pc reloads again; stay in DROP.
- Simultaneous push and pop leaves count unchanged. A full FIFO never receives a push, because no request is issued without a slot.
- Reset drives all of the following until reset is released:
  - mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC
  - count=0, op_valid=0, op_data=8'h00, op_pc=16'h0000
  - FSM in IDLE

## Timing
- First mem_req rises after the first ph1 edge following reset deassertion (IDLE→REQ).
- Memory to output latency is 1 cycle: mem_ack sampled at edge N gives op_valid=1 with that byte after edge N.
- Back-to-back acks sustain 1 byte/cycle. mem_addr advances on the edge of each ack.
- Flush to first new mem_req with address flush_pc:
  - 1 cycle from IDLE or from REQ with a same-cycle ack.
  - From DROP, 1 cycle after the pending ack.
- op_take at edge N: the next entry is visible after edge N.

## Configuration
- FETCH_IRQ_INJECT_EN defined:
  - While irq=1 and op_valid=1, op_data is forced to 8'h00 (BRK) and op_pc shows the head entry's pc.
  - op_take in this condition does not pop the FIFO, so the interrupted opcode is preserved for return.
  - Injection stops the cycle irq falls.
- FETCH_IRQ_INJECT_EN undefined: irq is ignored and op_data is always the head byte.

## Test plan
- Reset release with RESET_PC=16'h0200, mem_ack tied high, data 8'hA9,8'h01,… -> mem_addr 0200,0201,0202,0203. op_valid rises one cycle after the first ack with op_data=8'hA9, op_pc=16'h0200. count reaches 4 and mem_req drops.
- FIFO full, op_take held 1 for one cycle while mem_ack=1 -> exactly one new request issues. count stays ≤4. Output order is preserved with no duplicated or lost pc.
- flush with flush_pc=16'h8000 while in REQ without ack; ack arrives 2 cycles later with 8'hFF -> byte 8'hFF is discarded, count=0, next mem_addr=16'h8000.
- fetch_pc 16'hFFFF, ack with 8'hEA -> entry pc=16'hFFFF and next mem_addr=16'h0000.
- reset asserted mid-REQ with count=3 -> mem_req=0, count=0, op_valid=0 immediately (asynchronously).
- With FETCH_IRQ_INJECT_EN, irq=1, head 8'hA9@0204, op_take=1 -> op_data=8'h00, op_pc=16'h0204, count unchanged. Without the macro -> op_data=8'hA9 and the entry pops.

Source files
------------

// File: rtl/opcode_fetch_if.sv
// Purpose: bundles the memory read port and the control-unit opcode port of opcode_fetch.
// Latency: none, wires only.
// Backpressure: memory stalls by withholding mem_ack; control stalls by withholding op_take.
//
// Signals:
//   mem_req/mem_addr   read request and byte address toward memory
//   mem_ack/mem_data   read completion and returned byte
//   flush/flush_pc     restart the fetch stream at flush_pc
//   irq                interrupt pending (only used with FETCH_IRQ_INJECT_EN)
//   op_valid/op_data/op_pc/op_take   head-of-buffer handshake toward control
//   count              occupied buffer entries
interface opcode_fetch_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        flush;
    logic [15:0] flush_pc;
    logic        irq;
    logic        op_valid;
    logic [7:0]  op_data;
    logic [15:0] op_pc;
    logic        op_take;
    logic [2:0]  count;

    // master: the fetch stage itself
    modport master (
        output mem_req, mem_addr, op_valid, op_data, op_pc, count,
        input  mem_ack, mem_data, flush, flush_pc, irq, op_take
    );

    // slave: memory plus control unit surrounding the fetch stage
    modport slave (
        input  mem_req, mem_addr, op_valid, op_data, op_pc, count,
        output mem_ack, mem_data, flush, flush_pc, irq, op_take
    );
endinterface

// File: rtl/opcode_fetch.sv
// Purpose: opcode prefetch buffer; sequential byte reads from a fetch PC into a {byte,pc} FIFO.
// Latency: mem_ack at edge N -> byte visible on op_* after edge N; 1 byte/cycle sustained.
// Backpressure: no request is raised without a free slot; a raised request holds until mem_ack.
//
// Ports:
//   i_ph1    clock, all state on rising edge
//   i_reset  asynchronous active-low reset
//   bus      opcode_fetch_if.master (memory port, flush, irq, opcode handshake, count)
// Parameters: DEPTH (power of two, 2..8), RESET_PC.
// Optional feature macro: FETCH_IRQ_INJECT_EN -- while irq is high and an entry is
// available, present BRK (8'h00) at the head pc and refuse to pop on op_take.
module opcode_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0200
) (
    input  logic           i_ph1,
    input  logic           i_reset,
    opcode_fetch_if.master bus
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_fetch_pc, w_fetch_pc_nxt;
    logic [15:0]   r_req_addr;
    logic [3:0]    r_count, w_count_nxt, w_count_after_pop;
    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [7:0]    r_fifo_dat [DEPTH];
    logic [15:0]   r_fifo_pc  [DEPTH];
    logic          w_valid, w_pop, w_push, w_inject;

    assign w_valid = (r_count != 4'd0);

`ifdef FETCH_IRQ_INJECT_EN
    assign w_inject = bus.irq & w_valid;
`else
    logic w_unused_irq;
    assign w_inject     = 1'b0;
    assign w_unused_irq = bus.irq;
`endif

    // An injected BRK leaves the interrupted opcode at the head for the return path.
    assign w_pop             = bus.op_take & w_valid & ~w_inject;
    assign w_count_after_pop = r_count - {3'b000, w_pop};

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.flush) begin
                    w_fetch_pc_nxt = bus.flush_pc;
                    w_state_nxt    = S_REQ;
                end else if (w_count_after_pop < DEPTH_C) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.flush) begin
                    // A same-cycle ack retires the old request; otherwise it must still be drained.
                    w_fetch_pc_nxt = bus.flush_pc;
                    w_state_nxt    = bus.mem_ack ? S_REQ : S_DROP;
                end else if (bus.mem_ack) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 16'd1;
                    if ((w_count_after_pop + 4'd1) >= DEPTH_C)
                        w_state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                if (bus.flush) begin
                    w_fetch_pc_nxt = bus.flush_pc;
                    w_state_nxt    = bus.mem_ack ? S_REQ : S_DROP;
                end else if (bus.mem_ack) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count + {3'b000, w_push} - {3'b000, w_pop};
        if (bus.flush)
            w_count_nxt = 4'd0;
    end

    always_ff @(posedge i_ph1 or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_count    <= 4'd0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_count    <= w_count_nxt;
            // Freeze the outstanding address while draining so mem_addr stays put.
            if (r_state != S_DROP)
                r_req_addr <= r_fetch_pc;
            if (bus.flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Storage needs no reset; reads are gated by w_valid.
    always_ff @(posedge i_ph1) begin
        if (w_push) begin
            r_fifo_dat[r_wr_ptr] <= bus.mem_data;
            r_fifo_pc[r_wr_ptr]  <= r_fetch_pc;
        end
    end

    assign bus.mem_req  = (r_state != S_IDLE);
    assign bus.mem_addr = (r_state == S_DROP) ? r_req_addr : r_fetch_pc;
    assign bus.op_valid = w_valid;
    assign bus.op_data  = (w_valid && !w_inject) ? r_fifo_dat[r_rd_ptr] : 8'h00;
    assign bus.op_pc    = w_valid ? r_fifo_pc[r_rd_ptr] : 16'h0000;
    // count is 3 bits wide; a full DEPTH=8 buffer reads as 7.
    assign bus.count    = (r_count > 4'd7) ? 3'd7 : r_count[2:0];
endmodule
